rs_ap_ctrl_done_continue_pipeline: RTL and testbench
====================================================

// Module: rs_ap_ctrl_done_continue_pipeline
// PURPOSE
// Return-direction counterpart of the ap_ctrl start/ready relay pipeline.
// - Carries the kernel's ap_done to the host-side controller across BODY_LEVEL registered relay stages.
// - Carries the host's ap_continue back to the kernel across BODY_LEVEL stages.
// - Tail side faces the kernel (ap_ctrl_chain: done held high until continue). Head side faces the host.
// - Exactly one done/continue transaction is in flight at a time.
// PARAMETERS
// BODY_LEVEL  8   relay stages per direction; legal range 1..16
// CNT_WIDTH   32  width of completed-transaction counter
// PORTS
// clk               in   1          single clock for all stages
// reset             in   1          asynchronous, active-low reset
// kernel_ap_done    in   1          kernel done level; held until kernel_ap_continue
// kernel_ap_continue out 1          one-cycle continue pulse to kernel
// host_ap_done      out  1          done level presented to host controller
// host_ap_continue  in   1          host acknowledge; sampled only while host_ap_done=1
// done_count        out  CNT_WIDTH  completed handshakes, wraps at 2^CNT_WIDTH
// protocol_err      out  1          sticky; host_ap_continue seen while host_ap_done=0
// BEHAVIOUR
// - Reset (reset=0, async): all outputs 0; all relay stages empty; FSMs in IDLE.
//   Reset mid-transaction discards in-flight tokens.
//   After release, a still-high kernel_ap_done starts a new transaction.
// - Relay stage: 1-bit valid register.
//   - Advances when the next stage is empty or emptying (valid/ready with ready = !full | next_ready).
//   - No bubbles; one token per direction ever in flight.
// - Tail FSM (kernel side):
//   - T_IDLE: if kernel_ap_done=1, inject a done token into fwd stage 0, go to T_WAIT.
//   - T_WAIT: ignore kernel_ap_done. When a continue token exits the return pipe, go to T_CONT.
//   - T_CONT: kernel_ap_continue=1 for exactly this cycle; go to T_IDLE.
//     - The kernel drops done after continue, so T_IDLE re-samples the cycle after T_CONT.
//     - A done still high then counts as a new transaction (back-to-back runs).
// - Head FSM (host side):
//   - H_IDLE: when a done token exits the fwd pipe, go to H_DONE.
//   - H_DONE: host_ap_done=1 (registered). If host_ap_continue=1:
//     - inject a continue token into return stage 0;
//     - done_count += 1;
//     - go to H_IDLE, so host_ap_done=0 the next cycle.
// - Latency:
//   - kernel_ap_done rising at cycle t -> host_ap_done=1 at t+BODY_LEVEL+1.
//   - host_ap_continue at cycle c -> kernel_ap_continue pulse at c+BODY_LEVEL+2.
//   - Minimum round trip, done->next sample: 2*BODY_LEVEL+4 cycles.
// - host_ap_continue while host_ap_done=0: ignored, no token; sets protocol_err (cleared only by reset).
// - host_ap_continue in the same cycle a done token arrives in H_IDLE:
//   - ignored and flags protocol_err, since host_ap_done was still 0;
//   - the token still moves to H_DONE.
// - done_count wraps from all-ones to 0 without flagging.
// - kernel_ap_done glitch (high then low before transaction end) does not cancel the transaction.
// TESTING
// 1. BODY_LEVEL=8: reset release, kernel_ap_done=1 at cycle 10
//    -> host_ap_done=1 at cycle 19.
//    host_ap_continue pulse at 25 -> kernel_ap_continue pulse at 35, done_count=1.
// 2. kernel_ap_done held high continuously, host acks immediately each time
//    -> one host_ap_done per 20 cycles; done_count=5 after 5 transactions.
//    No duplicate done while one is in flight.
// 3. host_ap_continue=1 at cycle 5 with no transaction
//    -> protocol_err=1 and stays 1; kernel_ap_continue never pulses; done_count=0.
// 4. Assert reset for 1 cycle while the done token is in fwd stage 4
//    -> host_ap_done stays 0, all outputs 0.
//    With kernel_ap_done still 1, host_ap_done rises BODY_LEVEL+1 cycles after release.
// 5. CNT_WIDTH=2, four completed handshakes -> done_count sequence 1,2,3,0; protocol_err=0.
// 6. BODY_LEVEL=1: done at t -> host_ap_done at t+2; continue at c -> kernel_ap_continue at c+3.

Source files
------------

// File: rtl/rs_ap_ctrl_done_continue_pipeline.sv
// Return-direction ap_ctrl relay: carries kernel ap_done to the host and host
// ap_continue back to the kernel, each across BODY_LEVEL registered relay stages.

// Chain of 1-bit valid relay stages with a combinational ready back-path.
// Handshake: a token moves from a producer to a consumer on any clock edge where
// the producer's valid and the consumer's ready are both 1; a stage is ready when
// it is empty or its own token is leaving in the same cycle (ready = !full | next_ready).
module rs_relay_pipe #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready
);

    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_ready;
    logic             full_run;

    // Unrolled ready chain: stage i stalls only if it and every stage after it
    // are full and the sink is not taking the token.
    always_comb begin
        stage_ready = '0;
        full_run    = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            full_run       = full_run & stage_valid[i];
            stage_ready[i] = out_ready | ~full_run;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (stage_ready[i]) begin
                    stage_valid[i] <= (i == 0) ? in_valid : stage_valid[(i == 0) ? 0 : i - 1];
                end
            end
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_valid[DEPTH-1];

endmodule

module rs_ap_ctrl_done_continue_pipeline #(
    parameter int BODY_LEVEL = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 kernel_ap_done,
    output logic                 kernel_ap_continue,
    output logic                 host_ap_done,
    input  logic                 host_ap_continue,
    output logic [CNT_WIDTH-1:0] done_count,
    output logic                 protocol_err,
    output logic [1:0]           tail_state_dbg,
    output logic                 head_state_dbg
);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_WAIT = 2'd1,
        T_CONT = 2'd2
    } tail_state_t;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_DONE = 1'b1
    } head_state_t;

    tail_state_t tail_state, tail_next;
    head_state_t head_state, head_next;

    logic fwd_in_valid, fwd_in_ready, fwd_out_valid, fwd_out_ready;
    logic rtn_in_valid, rtn_in_ready, rtn_out_valid, rtn_out_ready;
    logic host_ack;
    logic rtn_launch;

    rs_relay_pipe #(.DEPTH(BODY_LEVEL)) u_fwd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fwd_in_valid),
        .in_ready  (fwd_in_ready),
        .out_valid (fwd_out_valid),
        .out_ready (fwd_out_ready)
    );

    rs_relay_pipe #(.DEPTH(BODY_LEVEL)) u_rtn_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rtn_in_valid),
        .in_ready  (rtn_in_ready),
        .out_valid (rtn_out_valid),
        .out_ready (rtn_out_ready)
    );

    // ---------------- tail FSM (kernel side) ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tail_state <= T_IDLE;
        end else begin
            tail_state <= tail_next;
        end
    end

    always_comb begin
        tail_next = tail_state;
        case (tail_state)
            T_IDLE:  if (kernel_ap_done && fwd_in_ready) tail_next = T_WAIT;
            T_WAIT:  if (rtn_out_valid) tail_next = T_CONT;
            T_CONT:  tail_next = T_IDLE;
            default: tail_next = T_IDLE;
        endcase
    end

    // kernel_ap_done is deliberately ignored outside T_IDLE so glitches cannot cancel a run.
    always_comb begin
        fwd_in_valid       = (tail_state == T_IDLE) && kernel_ap_done;
        rtn_out_ready      = (tail_state == T_WAIT);
        kernel_ap_continue = (tail_state == T_CONT);
    end

    // ---------------- head FSM (host side) ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_state <= H_IDLE;
        end else begin
            head_state <= head_next;
        end
    end

    always_comb begin
        head_next = head_state;
        case (head_state)
            H_IDLE:  if (fwd_out_valid) head_next = H_DONE;
            H_DONE:  if (host_ap_continue) head_next = H_IDLE;
            default: head_next = H_IDLE;
        endcase
    end

    always_comb begin
        fwd_out_ready = (head_state == H_IDLE);
        host_ap_done  = (head_state == H_DONE);
        host_ack      = (head_state == H_DONE) && host_ap_continue;
        rtn_in_valid  = rtn_launch;
    end

    // The host acknowledge is retimed through one flop before entering the return pipe,
    // which gives the continue path its extra cycle relative to the done path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rtn_launch   <= 1'b0;
            done_count   <= '0;
            protocol_err <= 1'b0;
        end else begin
            rtn_launch <= host_ack | (rtn_launch & ~rtn_in_ready);
            if (host_ack) begin
                done_count <= done_count + CNT_WIDTH'(1);
            end
            if (host_ap_continue && (head_state != H_DONE)) begin
                protocol_err <= 1'b1;
            end
        end
    end

    assign tail_state_dbg = tail_state;
    assign head_state_dbg = head_state;

endmodule

// File: tb/tb_rs_ap_ctrl_done_continue_pipeline.sv
// Bench for rs_ap_ctrl_done_continue_pipeline: one BODY_LEVEL=8/CNT_WIDTH=32 instance
// and one BODY_LEVEL=1/CNT_WIDTH=2 instance sharing stimulus, separate resets.
module tb_rs_ap_ctrl_done_continue_pipeline;

  logic clk;
  logic rst8, rst1;
  logic kd, hc;
  logic sel;

  logic        kc8, hd8, err8, hs8;
  logic [31:0] cnt8;
  logic [1:0]  ts8;
  logic        kc1, hd1, err1, hs1;
  logic [1:0]  cnt1;
  logic [1:0]  ts1;

  logic        obs_hd, obs_kc, obs_err;
  logic [31:0] obs_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rs_ap_ctrl_done_continue_pipeline #(.BODY_LEVEL(8), .CNT_WIDTH(32)) dut8 (
    .clk                (clk),
    .reset              (rst8),
    .kernel_ap_done     (kd),
    .kernel_ap_continue (kc8),
    .host_ap_done       (hd8),
    .host_ap_continue   (hc),
    .done_count         (cnt8),
    .protocol_err       (err8),
    .tail_state_dbg     (ts8),
    .head_state_dbg     (hs8)
  );

  rs_ap_ctrl_done_continue_pipeline #(.BODY_LEVEL(1), .CNT_WIDTH(2)) dut1 (
    .clk                (clk),
    .reset              (rst1),
    .kernel_ap_done     (kd),
    .kernel_ap_continue (kc1),
    .host_ap_done       (hd1),
    .host_ap_continue   (hc),
    .done_count         (cnt1),
    .protocol_err       (err1),
    .tail_state_dbg     (ts1),
    .head_state_dbg     (hs1)
  );

  assign obs_hd  = sel ? hd1  : hd8;
  assign obs_kc  = sel ? kc1  : kc8;
  assign obs_err = sel ? err1 : err8;
  assign obs_cnt = sel ? {30'b0, cnt1} : cnt8;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the selected instance released at the start of cycle 0 (#1 after posedge).
  task automatic do_reset(input logic s);
    kd   = 1'b0;
    hc   = 1'b0;
    rst8 = 1'b0;
    rst1 = 1'b0;
    sel  = s;
    repeat (3) @(posedge clk);
    #1;
    if (s) rst1 = 1'b1;
    else   rst8 = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel;
    int          cyc;
    logic        kd;
    logic        hc;
    logic        hd;
    logic        kc;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   seg_lo[$];

  function automatic void add(input logic s, input int c, input logic k, input logic h,
                              input logic ehd, input logic ekc, input logic [31:0] ecnt,
                              input logic eerr);
    vec_t v;
    v.sel = s; v.cyc = c; v.kd = k; v.hc = h;
    v.hd = ehd; v.kc = ekc; v.cnt = ecnt; v.err = eerr;
    vecs.push_back(v);
  endfunction

  task automatic run_segment(input int lo, input int hi);
    int idx;
    string tag;
    idx = lo;
    do_reset(vecs[lo].sel);
    for (int c = 0; c <= vecs[hi].cyc; c++) begin
      if (idx <= hi && vecs[idx].cyc == c) begin
        kd = vecs[idx].kd;
        hc = vecs[idx].hc;
      end
      @(negedge clk);
      if (idx <= hi && vecs[idx].cyc == c) begin
        tag = $sformatf("v%0d_c%0d", idx, c);
        check({tag, "_host_done"}, {31'b0, obs_hd}, {31'b0, vecs[idx].hd});
        check({tag, "_kcont"},     {31'b0, obs_kc}, {31'b0, vecs[idx].kc});
        check({tag, "_count"},     obs_cnt, vecs[idx].cnt);
        check({tag, "_perr"},      {31'b0, obs_err}, {31'b0, vecs[idx].err});
        idx++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scoreboard / sequences ----------------
  initial begin
    int rises, kpulses, last;

    // Single transaction, BODY_LEVEL=8: done at 10 -> host 19; continue 25 -> kernel 35.
    seg_lo.push_back(vecs.size());
    add(0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 10, 1, 0, 0, 0, 0, 0);
    add(0, 18, 1, 0, 0, 0, 0, 0);
    add(0, 19, 1, 0, 1, 0, 0, 0);
    add(0, 25, 1, 1, 1, 0, 0, 0);
    add(0, 26, 1, 0, 0, 0, 1, 0);
    add(0, 34, 1, 0, 0, 0, 1, 0);
    add(0, 35, 1, 0, 0, 1, 1, 0);
    add(0, 36, 0, 0, 0, 0, 1, 0);
    add(0, 50, 0, 0, 0, 0, 1, 0);
    // One-cycle done glitch still completes exactly one transaction.
    seg_lo.push_back(vecs.size());
    add(0,  0, 1, 0, 0, 0, 0, 0);
    add(0,  1, 0, 0, 0, 0, 0, 0);
    add(0,  8, 0, 0, 0, 0, 0, 0);
    add(0,  9, 0, 0, 1, 0, 0, 0);
    add(0, 10, 0, 1, 1, 0, 0, 0);
    add(0, 11, 0, 0, 0, 0, 1, 0);
    add(0, 19, 0, 0, 0, 0, 1, 0);
    add(0, 20, 0, 0, 0, 1, 1, 0);
    add(0, 21, 0, 0, 0, 0, 1, 0);
    add(0, 40, 0, 0, 0, 0, 1, 0);
    // Continue with nothing in flight: sticky error, no token.
    seg_lo.push_back(vecs.size());
    add(0,  0, 0, 0, 0, 0, 0, 0);
    add(0,  5, 0, 1, 0, 0, 0, 0);
    add(0,  6, 0, 0, 0, 0, 0, 1);
    add(0, 40, 0, 0, 0, 0, 0, 1);
    // Continue in the very cycle the done token lands: flagged, token still shown.
    seg_lo.push_back(vecs.size());
    add(0,  0, 1, 0, 0, 0, 0, 0);
    add(0,  8, 1, 1, 0, 0, 0, 0);
    add(0,  9, 1, 0, 1, 0, 0, 1);
    add(0, 12, 1, 1, 1, 0, 0, 1);
    add(0, 13, 1, 0, 0, 0, 1, 1);
    add(0, 21, 1, 0, 0, 0, 1, 1);
    add(0, 22, 1, 0, 0, 1, 1, 1);
    add(0, 23, 0, 0, 0, 0, 1, 1);
    add(0, 40, 0, 0, 0, 0, 1, 1);
    // BODY_LEVEL=1, CNT_WIDTH=2: latencies 2 and 3, count wraps 1,2,3,0.
    seg_lo.push_back(vecs.size());
    add(1,  0, 0, 0, 0, 0, 0, 0);
    add(1,  1, 1, 0, 0, 0, 0, 0);
    add(1,  2, 1, 0, 0, 0, 0, 0);
    add(1,  3, 1, 0, 1, 0, 0, 0);
    add(1,  4, 1, 1, 1, 0, 0, 0);
    add(1,  5, 1, 0, 0, 0, 1, 0);
    add(1,  6, 1, 0, 0, 0, 1, 0);
    add(1,  7, 1, 0, 0, 1, 1, 0);
    add(1,  8, 1, 0, 0, 0, 1, 0);
    add(1,  9, 1, 0, 0, 0, 1, 0);
    add(1, 10, 1, 1, 1, 0, 1, 0);
    add(1, 11, 1, 0, 0, 0, 2, 0);
    add(1, 13, 1, 0, 0, 1, 2, 0);
    add(1, 16, 1, 1, 1, 0, 2, 0);
    add(1, 17, 1, 0, 0, 0, 3, 0);
    add(1, 19, 1, 0, 0, 1, 3, 0);
    add(1, 22, 1, 1, 1, 0, 3, 0);
    add(1, 23, 1, 0, 0, 0, 0, 0);
    add(1, 25, 1, 0, 0, 1, 0, 0);
    add(1, 26, 0, 0, 0, 0, 0, 0);
    add(1, 30, 0, 0, 0, 0, 0, 0);
    seg_lo.push_back(vecs.size());

    for (int s = 0; s + 1 < seg_lo.size(); s++) begin
      run_segment(seg_lo[s], seg_lo[s+1] - 1);
    end

    // Back-to-back: done held high, host acks in the cycle host_ap_done appears.
    do_reset(1'b0);
    kd = 1'b1;
    rises = 0; kpulses = 0; last = 0;
    for (int c = 0; c < 100; c++) begin
      hc = hd8;
      if (hd8) begin
        rises++;
        if (rises == 1) check("b2b_first_done_cycle", c, 9);
        else            check("b2b_done_period", c - last, 20);
        last = c;
      end
      if (kc8) kpulses++;
      @(posedge clk);
      #1;
    end
    hc = 1'b0;
    kd = 1'b0;
    check("b2b_done_pulses", rises, 5);
    check("b2b_kcont_pulses", kpulses, 5);
    check("b2b_count", cnt8, 5);
    check("b2b_perr", {31'b0, err8}, 0);

    // Reset for one cycle while the done token sits in forward stage 4.
    do_reset(1'b0);
    kd = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst8 = 1'b0;
    #1;
    check("midrst_host_done", {31'b0, hd8}, 0);
    check("midrst_kcont", {31'b0, kc8}, 0);
    check("midrst_count", cnt8, 0);
    check("midrst_perr", {31'b0, err8}, 0);
    @(posedge clk);
    #1;
    rst8 = 1'b1;
    for (int c = 6; c <= 15; c++) begin
      @(negedge clk);
      check($sformatf("midrst_relaunch_c%0d", c), {31'b0, hd8}, (c >= 15) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    kd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a sequence stalls.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
